// File: rtl/odd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module   : odd_down_counter
//  Purpose  : Odd-value down counter. Steps TOP, TOP-2, ..., 3, 1 where
//             TOP = 2**WIDTH-1, then either wraps back to TOP (free-running)
//             or parks at 1 (one-shot). Adds count enable, parallel load,
//             a registered one-cycle terminal-count pulse and a busy flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     counter width in bits, legal range 2..16 (default 4)
//  Ports
//    clk       in   1      rising-edge clock
//    clear     in   1      asynchronous active-low reset
//    en        in   1      count enable, one step per cycle while high
//    load      in   1      synchronous load strobe, wins over en
//    load_val  in   WIDTH  load value, LSB forced to 1 when loaded
//    oneshot   in   1      1: stop at 1 (DONE), 0: wrap 1 -> TOP
//    Cout      out  WIDTH  current count (registered)
//    tc        out  1      terminal-count pulse (registered, one cycle)
//    busy      out  1      high while the FSM is in COUNT (registered)
//    wrap_cnt  out  8      saturating count of tc pulses
//                          (present only when ODD_DOWN_WRAP_CNT_EN is defined)
//  Configuration
//    ODD_DOWN_WRAP_CNT_EN  define to add the wrap_cnt output and its counter
// ============================================================================
module odd_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] Cout,
  output logic             tc,
  output logic             busy
`ifdef ODD_DOWN_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] c_TOP = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_TWO = WIDTH'(2);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_COUNT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cout_q,  cout_d;
  logic             tc_q,    tc_d;
  logic             busy_q,  busy_d;

  logic             w_is_one;
  logic             w_is_odd;
  logic             w_can_step;

  assign w_is_one   = (cout_q == c_ONE);
  assign w_is_odd   = cout_q[0];
  // Only IDLE and COUNT advance on en; DONE ignores it, and an unencoded
  // state is treated as not counting until it recovers.
  assign w_can_step = en && ((state_q == c_IDLE) || (state_q == c_COUNT));

  // --------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= c_IDLE;
      cout_q  <= c_TOP;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cout_q  <= cout_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = c_COUNT;
    end else begin
      case (state_q)
        c_IDLE, c_COUNT: begin
          if (en) begin
            // oneshot matters only on the step out of 1; an even (corrupt)
            // count is reloaded to TOP and keeps counting.
            if (w_is_odd && w_is_one && oneshot) begin
              state_d = c_DONE;
            end else begin
              state_d = c_COUNT;
            end
          end
        end
        c_DONE: begin
          state_d = c_DONE;
        end
        default: begin
          state_d = c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    cout_d = cout_q;
    tc_d   = 1'b0;
    if (load) begin
      cout_d = load_val | c_ONE;
    end else if (w_can_step) begin
      if (!w_is_odd) begin
        // Even value can only come from an upset; resynchronise to TOP.
        cout_d = c_TOP;
      end else if (w_is_one) begin
        tc_d   = 1'b1;
        cout_d = oneshot ? c_ONE : c_TOP;
      end else begin
        // Count is odd and at least 3 here, so no underflow is possible.
        cout_d = cout_q - c_TWO;
      end
    end
    busy_d = (state_d == c_COUNT);
  end

  assign Cout = cout_q;
  assign tc   = tc_q;
  assign busy = busy_q;

`ifdef ODD_DOWN_WRAP_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating wrap counter. Advances on the same edge that raises tc, so it
  // already includes the pulse currently shown on tc. Only clear resets it.
  // --------------------------------------------------------------------------
  logic [7:0] wrap_cnt_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wrap_cnt_q <= 8'd0;
    end else if (tc_d && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_q <= wrap_cnt_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  // Wrap counter not built: no extra port and no extra state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_odd_down_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_odd_down_counter
//  Purpose  : Self-checking bench for odd_down_counter (WIDTH = 4). Directed
//             scenarios plus randomized stimulus compared against a
//             position-in-sequence reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_odd_down_counter;

  localparam int WIDTH = 4;
  localparam int TOP   = (1 << WIDTH) - 1;
  localparam int LAST  = (TOP - 1) / 2;   // index of value 1 in TOP,TOP-2,..,1

  logic             clk = 1'b0;
  logic             clear;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic [WIDTH-1:0] Cout;
  logic             tc;
  logic             busy;
`ifdef ODD_DOWN_WRAP_CNT_EN
  logic [7:0]       wrap_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  odd_down_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .oneshot  (oneshot),
    .Cout     (Cout),
    .tc       (tc),
    .busy     (busy)
`ifdef ODD_DOWN_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  // --------------------------------------------------------------------------
  // Reference model: position within the odd sequence TOP, TOP-2, ..., 1
  // --------------------------------------------------------------------------
  int m_pos;
  bit m_run;
  bit m_stop;
  bit m_tc;
  int m_wrap;

  function automatic logic [WIDTH-1:0] m_cout();
    return WIDTH'(TOP - 2 * m_pos);
  endfunction

  function automatic logic m_busy();
    return m_run && !m_stop;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_run  = 1'b0;
    m_stop = 1'b0;
    m_tc   = 1'b0;
    m_wrap = 0;
  endtask

  task automatic model_step();
    m_tc = 1'b0;
    if (load) begin
      m_pos  = (TOP - (int'(load_val) | 1)) / 2;
      m_run  = 1'b1;
      m_stop = 1'b0;
    end else if (en && !m_stop) begin
      m_run = 1'b1;
      if (m_pos == LAST) begin
        m_tc = 1'b1;
        if (oneshot) m_stop = 1'b1;
        else         m_pos  = 0;
      end else begin
        m_pos++;
      end
    end
    if (m_tc && m_wrap < 255) m_wrap++;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then land 1 time unit after the edge for sampling.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    oneshot  = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Cout !== 4'd15) begin
      errors++;
      $display("FAIL reset_cout: got %0d expected 15", Cout);
    end
    checks++;
    if (tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got tc=%b busy=%b expected tc=0 busy=0", tc, busy);
    end
    clear = 1'b1;
    repeat (2) cycle();
    checks++;
    if (Cout !== 4'd15 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got Cout=%0d tc=%b busy=%b expected 15/0/0", Cout, tc, busy);
    end
  endtask

  task automatic test_free_run();
    int exp_seq [9] = '{13, 11, 9, 7, 5, 3, 1, 15, 13};
    en      = 1'b1;
    oneshot = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (Cout !== WIDTH'(exp_seq[i]) || tc !== (exp_seq[i] == 15) || busy !== 1'b1) begin
        errors++;
        $display("FAIL free_run step %0d: got Cout=%0d tc=%b busy=%b expected Cout=%0d tc=%b busy=1",
                 i, Cout, tc, busy, exp_seq[i], (exp_seq[i] == 15));
      end
    end
  endtask

  task automatic test_load();
    int exp_seq [3] = '{5, 3, 1};
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'd6;
    cycle();
    load = 1'b0;
    checks++;
    if (Cout !== 4'd7 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_even: got Cout=%0d busy=%b tc=%b expected 7/1/0", Cout, busy, tc);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (Cout !== WIDTH'(exp_seq[i]) || tc !== 1'b0) begin
        errors++;
        $display("FAIL load_count step %0d: got Cout=%0d tc=%b expected %0d tc=0",
                 i, Cout, tc, exp_seq[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_oneshot();
    int tc_seen = 0;
    oneshot  = 1'b1;
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'd3;
    cycle();
    load = 1'b0;
    checks++;
    if (Cout !== 4'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_load: got Cout=%0d busy=%b expected 3/1", Cout, busy);
    end
    en = 1'b1;
    cycle();
    checks++;
    if (Cout !== 4'd1 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_to1: got Cout=%0d tc=%b busy=%b expected 1/0/1", Cout, tc, busy);
    end
    cycle();
    checks++;
    if (Cout !== 4'd1 || tc !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_done: got Cout=%0d tc=%b busy=%b expected 1/1/0", Cout, tc, busy);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (tc === 1'b1) tc_seen++;
      checks++;
      if (Cout !== 4'd1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL oneshot_park cycle %0d: got Cout=%0d busy=%b expected 1/0", i, Cout, busy);
      end
    end
    checks++;
    if (tc_seen != 0) begin
      errors++;
      $display("FAIL oneshot_tc_once: got %0d extra tc pulses expected 0", tc_seen);
    end
  endtask

  task automatic test_load_vs_en();
    load     = 1'b1;
    en       = 1'b1;
    load_val = 4'd9;
    cycle();
    load = 1'b0;
    en   = 1'b0;
    checks++;
    if (Cout !== 4'd9 || busy !== 1'b1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_vs_en: got Cout=%0d busy=%b tc=%b expected 9/1/0", Cout, busy, tc);
    end
    oneshot = 1'b0;
  endtask

  task automatic test_async_clear();
    load     = 1'b1;
    load_val = 4'd5;
    cycle();
    load = 1'b0;
    en   = 1'b1;
    checks++;
    if (Cout !== 4'd5) begin
      errors++;
      $display("FAIL clear_setup: got Cout=%0d expected 5", Cout);
    end
    #3;
    clear = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Cout !== 4'd15 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: got Cout=%0d tc=%b busy=%b expected 15/0/0", Cout, tc, busy);
    end
    @(posedge clk);
    #1;
    clear = 1'b1;
    en    = 1'b0;
    cycle();
    checks++;
    if (Cout !== 4'd15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_release: got Cout=%0d busy=%b expected 15/0", Cout, busy);
    end
    // First enabled step out of IDLE.
    en = 1'b1;
    cycle();
    en = 1'b0;
    checks++;
    if (Cout !== 4'd13 || busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_first_step: got Cout=%0d busy=%b expected 13/1", Cout, busy);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_c;
    int               prev_tc = 0;
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) < 7);
      load     = ($urandom_range(0, 9) == 0);
      load_val = WIDTH'($urandom);
      if ($urandom_range(0, 19) == 0) oneshot = ~oneshot;
      cycle();
      exp_c = m_cout();
      checks++;
      if (Cout !== exp_c || tc !== m_tc || busy !== m_busy()) begin
        errors++;
        $display("FAIL random cycle %0d: got Cout=%0d tc=%b busy=%b expected Cout=%0d tc=%b busy=%b",
                 i, Cout, tc, busy, exp_c, m_tc, m_busy());
      end
      checks++;
      if (prev_tc == 1 && tc === 1'b1) begin
        errors++;
        $display("FAIL random_tc_double cycle %0d: got tc=1 twice expected single pulse", i);
      end
      prev_tc = (tc === 1'b1) ? 1 : 0;
`ifdef ODD_DOWN_WRAP_CNT_EN
      checks++;
      if (wrap_cnt !== 8'(m_wrap)) begin
        errors++;
        $display("FAIL random_wrap cycle %0d: got %0d expected %0d", i, wrap_cnt, m_wrap);
      end
`endif
    end
    idle_inputs();
  endtask

`ifdef ODD_DOWN_WRAP_CNT_EN
  task automatic test_wrap_cnt();
    test_reset();
    en      = 1'b1;
    oneshot = 1'b0;
    repeat (300 * (LAST + 1)) cycle();
    en = 1'b0;
    checks++;
    if (wrap_cnt !== 8'd255 || m_wrap != 255) begin
      errors++;
      $display("FAIL wrap_saturate: got %0d expected 255", wrap_cnt);
    end
    // Load must not disturb the wrap count.
    load     = 1'b1;
    load_val = 4'd7;
    cycle();
    load = 1'b0;
    checks++;
    if (wrap_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_load_keep: got %0d expected 255", wrap_cnt);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (wrap_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_clear: got %0d expected 0", wrap_cnt);
    end
    @(posedge clk);
    #1;
    clear = 1'b1;
    model_reset();
  endtask
`endif

  initial begin
    clear = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_free_run();
    test_load();
    test_oneshot();
    test_load_vs_en();
    test_async_clear();
    test_reset();
    test_random();
`ifdef ODD_DOWN_WRAP_CNT_EN
    test_wrap_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
